// File: rtl/pal_sync_gen.sv
// pal_sync_gen: PAL raster timing generator.
// Produces hsync/vsync, porch/data-enable, active pixel coordinates, a line
// strobe and field parity. Every output is registered one clock after the
// h/v counter state it decodes.
// Build option: define PAL_INTERLACE_EN for 313/312-line interlaced fields
// with a half-line vsync offset in field 1; otherwise every field is V_TOTAL
// lines with line-aligned vsync.

`timescale 1ns/1ps

module pal_sync_gen #(
    parameter int H_TOTAL      = 1536,
    parameter int H_SYNC       = 113,
    parameter int H_ACT_START  = 264,
    parameter int H_ACT_END    = 1480,
    parameter int V_TOTAL      = 312,
    parameter int V_SYNC_LINES = 3,
    parameter int V_ACT_START  = 23,
    parameter int V_ACT_END    = 311
) (
    input  logic        clk24,
    input  logic        reset,
    output logic        hs_n,
    output logic        vs_n,
    output logic        porch,
    output logic        de,
    output logic [10:0] pix_x,
    output logic [8:0]  pix_y,
    output logic        line_stb,
    output logic        field
);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] H_SYNC_C = 11'(H_SYNC);
    localparam logic [10:0] H_AS_C   = 11'(H_ACT_START);
    localparam logic [10:0] H_AE_C   = 11'(H_ACT_END);
    localparam logic [8:0]  V_LAST   = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_SYNC_C = 9'(V_SYNC_LINES);
    localparam logic [8:0]  V_AS_C   = 9'(V_ACT_START);
    localparam logic [8:0]  V_AE_C   = 9'(V_ACT_END);
`ifdef PAL_INTERLACE_EN
    // Field 0 carries the extra line of the 625-line frame.
    localparam logic [8:0]  V_LAST_LONG = 9'(V_TOTAL);
    localparam logic [10:0] H_HALF      = 11'(H_TOTAL / 2);
`endif

    // Timing counters (fld_q is the counter-side field, field_q the output copy)
    logic [10:0] h_cnt_q, h_cnt_d;
    logic [8:0]  v_cnt_q, v_cnt_d;
    logic        fld_q, fld_d;

    // Registered outputs
    logic        hs_n_q, hs_n_d;
    logic        vs_n_q, vs_n_d;
    logic        porch_q, porch_d;
    logic        de_q, de_d;
    logic [10:0] pix_x_q, pix_x_d;
    logic [8:0]  pix_y_q, pix_y_d;
    logic        line_stb_q, line_stb_d;
    logic        field_q, field_d;

    logic        h_wrap;
    logic        v_wrap;
    logic [8:0]  v_last;
    logic        vs_low;
    logic        active;

    // Counter advance: h wraps every line, v wraps at the field's last line
    always_comb begin
        h_wrap  = (h_cnt_q == H_LAST);
`ifdef PAL_INTERLACE_EN
        v_last  = fld_q ? V_LAST : V_LAST_LONG;
`else
        v_last  = V_LAST;
`endif
        v_wrap  = (v_cnt_q == v_last);
        h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
        v_cnt_d = v_cnt_q;
        fld_d   = fld_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 9'd0 : v_cnt_q + 9'd1;
            if (v_wrap) begin
                fld_d = ~fld_q;
            end
        end
    end

    // Output decode from the current counter state
    always_comb begin
`ifdef PAL_INTERLACE_EN
        if (fld_q) begin
            vs_low = ((v_cnt_q == 9'd0) && (h_cnt_q >= H_HALF))
                  || ((v_cnt_q != 9'd0) && (v_cnt_q < V_SYNC_C))
                  || ((v_cnt_q == V_SYNC_C) && (h_cnt_q < H_HALF));
        end else begin
            vs_low = (v_cnt_q < V_SYNC_C);
        end
`else
        vs_low = (v_cnt_q < V_SYNC_C);
`endif
        active = (h_cnt_q >= H_AS_C) && (h_cnt_q < H_AE_C)
              && (v_cnt_q >= V_AS_C) && (v_cnt_q < V_AE_C);

        hs_n_d     = ~(h_cnt_q < H_SYNC_C);
        vs_n_d     = ~vs_low;
        porch_d    = ~active;
        de_d       = active;
        pix_x_d    = active ? (h_cnt_q - H_AS_C) : 11'd0;
        pix_y_d    = active ? (v_cnt_q - V_AS_C) : 9'd0;
        line_stb_d = (h_cnt_q == 11'd0);
        field_d    = fld_q;
    end

    // State and output registers; reset aborts the line/field at once
    always_ff @(posedge clk24) begin
        if (reset) begin
            h_cnt_q    <= 11'd0;
            v_cnt_q    <= 9'd0;
            fld_q      <= 1'b0;
            hs_n_q     <= 1'b1;
            vs_n_q     <= 1'b1;
            porch_q    <= 1'b1;
            de_q       <= 1'b0;
            pix_x_q    <= 11'd0;
            pix_y_q    <= 9'd0;
            line_stb_q <= 1'b0;
            field_q    <= 1'b0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            fld_q      <= fld_d;
            hs_n_q     <= hs_n_d;
            vs_n_q     <= vs_n_d;
            porch_q    <= porch_d;
            de_q       <= de_d;
            pix_x_q    <= pix_x_d;
            pix_y_q    <= pix_y_d;
            line_stb_q <= line_stb_d;
            field_q    <= field_d;
        end
    end

    assign hs_n     = hs_n_q;
    assign vs_n     = vs_n_q;
    assign porch    = porch_q;
    assign de       = de_q;
    assign pix_x    = pix_x_q;
    assign pix_y    = pix_y_q;
    assign line_stb = line_stb_q;
    assign field    = field_q;

endmodule

// File: tb/tb_pal_sync_gen.sv
// Bench for pal_sync_gen: a full-size instance driven through a table of
// checkpoints, and a reduced-geometry instance exercised over whole frames
// and random reset pulses. Both are also compared every clock against a
// position-from-elapsed-time reference model.

`timescale 1ns/1ps

module tb_pal_sync_gen;

    // Full-size geometry
    localparam int B_HT = 1536, B_HS = 113, B_HAS = 264, B_HAE = 1480;
    localparam int B_VT = 312,  B_VSL = 3,  B_VAS = 23,  B_VAE = 311;
    // Reduced geometry so whole fields fit in a short run
    localparam int S_HT = 40, S_HS = 5, S_HAS = 10, S_HAE = 36;
    localparam int S_VT = 12, S_VSL = 2, S_VAS = 4, S_VAE = 11;

    localparam logic [25:0] RST_V = {1'b1, 1'b1, 1'b1, 1'b0, 11'd0, 9'd0, 1'b0, 1'b0};

    logic clk24 = 1'b0;
    logic rst_b = 1'b1;
    logic rst_s = 1'b1;

    logic        hs_n_b, vs_n_b, porch_b, de_b, line_stb_b, field_b;
    logic [10:0] pix_x_b;
    logic [8:0]  pix_y_b;
    logic        hs_n_s, vs_n_s, porch_s, de_s, line_stb_s, field_s;
    logic [10:0] pix_x_s;
    logic [8:0]  pix_y_s;

    int n_cmp  = 0;
    int n_fail = 0;

    int k_b = 0, k_s = 0;
    bit rd_b = 1'b0, rd_s = 1'b0;
    bit seen_b = 1'b0, seen_s = 1'b0;

    always #5 clk24 = ~clk24;

    pal_sync_gen dut (
        .clk24(clk24), .reset(rst_b),
        .hs_n(hs_n_b), .vs_n(vs_n_b), .porch(porch_b), .de(de_b),
        .pix_x(pix_x_b), .pix_y(pix_y_b), .line_stb(line_stb_b), .field(field_b)
    );

    pal_sync_gen #(
        .H_TOTAL(S_HT), .H_SYNC(S_HS), .H_ACT_START(S_HAS), .H_ACT_END(S_HAE),
        .V_TOTAL(S_VT), .V_SYNC_LINES(S_VSL), .V_ACT_START(S_VAS), .V_ACT_END(S_VAE)
    ) dut_s (
        .clk24(clk24), .reset(rst_s),
        .hs_n(hs_n_s), .vs_n(vs_n_s), .porch(porch_s), .de(de_s),
        .pix_x(pix_x_s), .pix_y(pix_y_s), .line_stb(line_stb_s), .field(field_s)
    );

    // Expected outputs after n clocks of free running since reset release:
    // position is recovered from n by division, fields by line arithmetic.
    function automatic logic [25:0] model(input int ht, hsy, has, hae,
                                          input int vt, vsl, vas, vae, input int n);
        int h, line, v, f;
        bit vlow, act;
        logic [10:0] px;
        logic [8:0]  py;
        h    = n % ht;
        line = n / ht;
`ifdef PAL_INTERLACE_EN
        line = line % (2 * vt + 1);
        if (line < vt + 1) begin f = 0; v = line; end
        else begin f = 1; v = line - (vt + 1); end
        if (f == 1)
            vlow = (v == 0 && h >= ht / 2) || (v > 0 && v < vsl) || (v == vsl && h < ht / 2);
        else
            vlow = (v < vsl);
`else
        v    = line % vt;
        f    = (line / vt) % 2;
        vlow = (v < vsl);
`endif
        act = (h >= has) && (h < hae) && (v >= vas) && (v < vae);
        px  = act ? 11'(h - has) : 11'd0;
        py  = act ? 9'(v - vas) : 9'd0;
        return {(h >= hsy), !vlow, !act, act, px, py, (h == 0), (f == 1)};
    endfunction

    function automatic logic [25:0] pk(bit hs, bit vs, bit po, bit d, int px, int py, bit stb, bit f);
        return {hs, vs, po, d, 11'(px), 9'(py), stb, f};
    endfunction

    task automatic chk(input string nm, input logic [25:0] act, input logic [25:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Elapsed-clock trackers for the reference model
    initial forever begin
        @(posedge clk24);
        rd_b = rst_b;
        rd_s = rst_s;
        k_b  = rst_b ? 0 : k_b + 1;
        k_s  = rst_s ? 0 : k_s + 1;
        if (rst_b) seen_b = 1'b1;
        if (rst_s) seen_s = 1'b1;
    end

    // Every-clock comparison of both instances against the model
    initial forever begin
        logic [25:0] e, a;
        @(negedge clk24);
        if (seen_b && n_fail < 100) begin
            e = rd_b ? RST_V : model(B_HT, B_HS, B_HAS, B_HAE, B_VT, B_VSL, B_VAS, B_VAE, k_b - 1);
            a = {hs_n_b, vs_n_b, porch_b, de_b, pix_x_b, pix_y_b, line_stb_b, field_b};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model_big n=%0d: got %h expected %h", k_b - 1, a, e);
            end
        end
        if (seen_s && n_fail < 100) begin
            e = rd_s ? RST_V : model(S_HT, S_HS, S_HAS, S_HAE, S_VT, S_VSL, S_VAS, S_VAE, k_s - 1);
            a = {hs_n_s, vs_n_s, porch_s, de_s, pix_x_s, pix_y_s, line_stb_s, field_s};
            n_cmp++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL model_small n=%0d: got %h expected %h", k_s - 1, a, e);
            end
        end
    end

    typedef struct {
        bit          rst;
        int          adv;
        logic [25:0] exp;
        string       nm;
    } vec_t;

    function automatic vec_t mk(input bit r, input int a, input logic [25:0] e, input string s);
        vec_t v;
        v.rst = r; v.adv = a; v.exp = e; v.nm = s;
        return v;
    endfunction

    // Full-size checkpoints; adv = clock edges before sampling
    task automatic run_big();
        vec_t vecs[$];
        vecs.push_back(mk(1, 3,     RST_V,                         "reset_hold"));
        vecs.push_back(mk(0, 1,     pk(0, 0, 1, 0, 0, 0, 1, 0),    "first_line"));
        vecs.push_back(mk(0, 112,   pk(0, 0, 1, 0, 0, 0, 0, 0),    "hs_last_low"));
        vecs.push_back(mk(0, 1,     pk(1, 0, 1, 0, 0, 0, 0, 0),    "hs_rise"));
        vecs.push_back(mk(0, 1422,  pk(1, 0, 1, 0, 0, 0, 0, 0),    "line0_end"));
        vecs.push_back(mk(0, 1,     pk(0, 0, 1, 0, 0, 0, 1, 0),    "line1_stb"));
        vecs.push_back(mk(0, 3071,  pk(1, 0, 1, 0, 0, 0, 0, 0),    "vs_last_low"));
        vecs.push_back(mk(0, 1,     pk(0, 1, 1, 0, 0, 0, 1, 0),    "vs_rise"));
        vecs.push_back(mk(0, 30983, pk(1, 1, 1, 0, 0, 0, 0, 0),    "pre_active"));
        vecs.push_back(mk(0, 1,     pk(1, 1, 0, 1, 0, 0, 0, 0),    "de_rise"));
        vecs.push_back(mk(0, 1215,  pk(1, 1, 0, 1, 1215, 0, 0, 0), "last_pix"));
        vecs.push_back(mk(0, 1,     pk(1, 1, 1, 0, 0, 0, 0, 0),    "de_fall"));
        vecs.push_back(mk(0, 320,   pk(1, 1, 0, 1, 0, 1, 0, 0),    "line24_first"));
        vecs.push_back(mk(0, 436,   pk(1, 1, 0, 1, 436, 1, 0, 0),  "mid_line"));
        vecs.push_back(mk(1, 1,     RST_V,                         "abort"));
        vecs.push_back(mk(0, 1,     pk(0, 0, 1, 0, 0, 0, 1, 0),    "restart"));
        @(negedge clk24);
        foreach (vecs[i]) begin
            rst_b = vecs[i].rst;
            repeat (vecs[i].adv) @(posedge clk24);
            @(negedge clk24);
            chk(vecs[i].nm, {hs_n_b, vs_n_b, porch_b, de_b, pix_x_b, pix_y_b, line_stb_b, field_b},
                vecs[i].exp);
        end
    endtask

    // Reduced geometry: frame-level properties, mid-field abort, random resets
    task automatic run_small();
        int tf, stb0, stb1, delines0, since_fall, gap, nfall, since_stb, vs_off1;
        int comp_lo, comp_hi, fld_end, n, lines0_exp, gap_exp, off_exp;
        bit seen1, de_flag, prev_vs;
`ifdef PAL_INTERLACE_EN
        tf = (2 * S_VT + 1) * S_HT; lines0_exp = S_VT + 1; gap_exp = S_VT + 2; off_exp = S_HT / 2;
`else
        tf = 2 * S_VT * S_HT;       lines0_exp = S_VT;     gap_exp = S_VT;     off_exp = 0;
`endif
        stb0 = 0; stb1 = 0; delines0 = 0; since_fall = 0; gap = -1; nfall = 0;
        since_stb = 0; vs_off1 = -1; comp_lo = 0; comp_hi = 0; fld_end = -1;
        seen1 = 0; de_flag = 0; prev_vs = 1;

        @(negedge clk24);
        rst_s = 1;
        repeat (2) @(posedge clk24);
        @(negedge clk24);
        rst_s = 0;
        for (int j = 1; j <= tf + 1; j++) begin
            @(posedge clk24);
            @(negedge clk24);
            n = j - 1;
            if (j == tf + 1) begin
                fld_end = int'(field_s);
            end else begin
                since_stb = line_stb_s ? 0 : since_stb + 1;
                if (prev_vs && !vs_n_s) begin
                    if (nfall == 1) gap = since_fall;
                    nfall++;
                    since_fall = 0;
                    if (field_s) vs_off1 = since_stb;
                end
                if (line_stb_s) begin
                    since_fall++;
                    if (field_s) stb1++; else stb0++;
                    de_flag = 0;
                end
                if (de_s && !de_flag && !field_s) begin
                    delines0++;
                    de_flag = 1;
                end
                if (field_s) seen1 = 1;
                if (n >= S_HT && n < 2 * S_HT) begin
                    if (~(hs_n_s ^ vs_n_s)) comp_hi++; else comp_lo++;
                end
            end
            prev_vs = vs_n_s;
        end
        chki("lines_field0", stb0, lines0_exp);
        chki("lines_field1", stb1, S_VT);
        chki("frame_strobes", stb0 + stb1, lines0_exp + S_VT);
        chki("stb_between_vs_falls", gap, gap_exp);
        chki("de_lines", delines0, S_VAE - S_VAS);
        chki("field_toggled", int'(seen1), 1);
        chki("field_back", fld_end, 0);
        chki("vs_offset_field1", vs_off1, off_exp);
        chki("composite_broad_low", comp_lo, S_HT - S_HS);
        chki("composite_serration", comp_hi, S_HS);

        // Into the next frame: line 8, h 27, then a one-clock reset pulse
        repeat (8 * S_HT + 27) @(posedge clk24);
        @(negedge clk24);
        chk("pre_abort", {hs_n_s, vs_n_s, porch_s, de_s, pix_x_s, pix_y_s, line_stb_s, field_s},
            pk(1, 1, 0, 1, 27 - S_HAS, 8 - S_VAS, 0, 0));
        rst_s = 1;
        @(posedge clk24);
        @(negedge clk24);
        chk("abort_small", {hs_n_s, vs_n_s, porch_s, de_s, pix_x_s, pix_y_s, line_stb_s, field_s},
            RST_V);
        rst_s = 0;
        @(posedge clk24);
        @(negedge clk24);
        chk("restart_small", {hs_n_s, vs_n_s, porch_s, de_s, pix_x_s, pix_y_s, line_stb_s, field_s},
            pk(0, 0, 1, 0, 0, 0, 1, 0));

        for (int it = 0; it < 25; it++) begin
            int len, rl;
            len = int'($urandom_range(1, 1100));
            rl  = int'($urandom_range(1, 3));
            repeat (len) @(posedge clk24);
            @(negedge clk24);
            rst_s = 1;
            repeat (rl) @(posedge clk24);
            @(negedge clk24);
            rst_s = 0;
        end
        repeat (600) @(posedge clk24);
        @(negedge clk24);
    endtask

    initial begin
        if (!(B_HS < B_HAS && B_HAS < B_HAE && B_HAE <= B_HT && B_VSL < B_VAS &&
              B_VAS < B_VAE && B_VAE <= B_VT && S_HS < S_HAS && S_HAS < S_HAE &&
              S_HAE <= S_HT && S_VSL < S_VAS && S_VAS < S_VAE && S_VAE <= S_VT)) begin
            $display("FAIL param_order: geometry parameters are not ordered");
            $fatal(1);
        end
        fork
            run_big();
            run_small();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: time limit reached before bench completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1);
    end

endmodule

// File: doc/pal_sync_gen.md
# pal_sync_gen

Upstream timing stage for the PAL composite encoder. Generates the horizontal and vertical sync pair, the porch/blank flag and pixel coordinates at the 24 MHz system clock. The encoder consumes `hs_n`, `vs_n` and `porch` directly as its `tv_hs_i`, `tv_vs_i` and `tv_porch_i` inputs. `de`, `pix_x` and `pix_y` drive the framebuffer fetch that supplies the encoder's 6-bit RGB.

## Interface
Parameters:
- `H_TOTAL`, 1536: clocks per line (64 µs at 24 MHz).
- `H_SYNC`, 113: hsync low width in clocks (4.7 µs).
- `H_ACT_START`, 264: first active clock of a line.
- `H_ACT_END`, 1480: first blank clock after the active region (exclusive).
- `V_TOTAL`, 312: lines per field.
- `V_SYNC_LINES`, 3: lines with `vs_n` low, starting at line 0.
- `V_ACT_START`, 23: first active line.
- `V_ACT_END`, 311: first blank line after the active region (exclusive).

Ports:
- `clk24`, in, 1: system clock; every register updates on its rising edge.
- `reset`, in, 1: synchronous, active-high.
- `hs_n`, out, 1: horizontal sync, active low.
- `vs_n`, out, 1: vertical sync, active low. The encoder forms composite sync as ~(hs ^ vs), which produces serrated broad pulses.
- `porch`, out, 1: high outside the active window, horizontally or vertically.
- `de`, out, 1: equals ~`porch`. Marks a valid pixel request.
- `pix_x`, out, 11: active-region column, 0 at `H_ACT_START`.
- `pix_y`, out, 9: active-region row, 0 at `V_ACT_START`.
- `line_stb`, out, 1: one-clock pulse on the first clock of each line.
- `field`, out, 1: field parity. Toggles at the start of each field.

## Operation
- Internal counters:
  - `h_cnt` (11 bit) runs 0..`H_TOTAL`-1 and wraps to 0.
  - `v_cnt` (9 bit) advances when `h_cnt` wraps. It wraps to 0 after the last line of the field.
  - `field` toggles on the clock where both counters wrap together.
- Output decode, all from the current `h_cnt`/`v_cnt`:
  - `hs_n` = 0 when `h_cnt` < `H_SYNC`.
  - `vs_n` = 0 when `v_cnt` < `V_SYNC_LINES`.
  - `porch` = 1 unless `H_ACT_START` ≤ `h_cnt` < `H_ACT_END` and `V_ACT_START` ≤ `v_cnt` < `V_ACT_END`.
  - `pix_x` = `h_cnt` − `H_ACT_START`. Held at 0 while `de` = 0.
  - `pix_y` = `v_cnt` − `V_ACT_START`. Held at 0 while `de` = 0.
  - `line_stb` = 1 when `h_cnt` == 0.
- Arithmetic: subtractions are 11/9-bit unsigned. The results are meaningful only inside the active window; outside it the held value of 0 applies.
- `vs_n` changes only on the same clock as a `line_stb` pulse, except for field 1 under `PAL_INTERLACE_EN` (see Configuration).
- Reset:
  - While `reset` = 1: `h_cnt` = 0, `v_cnt` = 0, `field` = 0. All outputs are held at `hs_n`=1, `vs_n`=1, `porch`=1, `de`=0, `pix_x`=0, `pix_y`=0, `line_stb`=0.
  - Reset asserted mid-line or mid-field aborts the current line or field immediately. No partial pulse is completed.

## Timing
- All outputs are registered, with one clock of latency from the counter state.
- First clock after `reset` deasserts:
  - Counters are at (0,0).
  - On the following edge the outputs become `hs_n`=0, `vs_n`=0, `line_stb`=1.
- A full line is `H_TOTAL` clocks.
- `hs_n` low lasts exactly `H_SYNC` clocks.
- `de` high lasts exactly `H_ACT_END` − `H_ACT_START` = 1216 clocks per active line, with `pix_x` counting 0..1215.
- `line_stb` and the hs falling edge coincide.
- On the last active pixel of a field (`pix_x` = 1215, `pix_y` = 287):
  - The next clock has `de` = 0.
  - The next `de` = 1 occurs only in the next field, at `pix_y` = 0.
- Parameters are elaboration-time constants. The bench checks `H_SYNC` < `H_ACT_START` < `H_ACT_END` ≤ `H_TOTAL` and the equivalent vertical ordering.

## Configuration
- `PAL_INTERLACE_EN` defined:
  - Fields alternate between 313 lines (`field`=0) and 312 lines (`field`=1), giving a 625-line frame.
  - In `field`=1, `vs_n` falls at `h_cnt` = `H_TOTAL`/2 of line 0 and rises at `h_cnt` = `H_TOTAL`/2 of line `V_SYNC_LINES`. This produces the half-line vsync offset.
- `PAL_INTERLACE_EN` undefined:
  - Every field is `V_TOTAL` = 312 lines and vsync is line-aligned (progressive 50.08 Hz).
  - `field` still toggles so that the encoder's optional field alternation keeps working.

## Test plan
- Reset release, 3 lines observed:
  - `hs_n` low for 113 clocks per line.
  - `line_stb` period is 1536 clocks.
  - `vs_n` low for exactly 3×1536 clocks.
- Active window on line 23:
  - `de` rises 264 clocks after `line_stb` and stays high for 1216 clocks.
  - `pix_x` runs 0..1215 and `pix_y` = 0.
- Full field, macro off:
  - 312 `line_stb` pulses between `vs_n` falling edges.
  - `field` toggles 0→1→0 across two fields.
  - 288 lines contain `de`.
- Macro on, two fields:
  - Line counts are 313 then 312.
  - In field 1, `vs_n` falls 768 clocks after `line_stb`.
  - Total of 625 line strobes per frame.
- `reset` pulsed for 1 clock at `h_cnt` = 700, `v_cnt` = 100:
  - All outputs return to their reset values on the next edge.
  - The timing restarts from (0,0) and the next `vs_n` falls immediately.
- Composite check through the encoder's ~(hs ^ vs):
  - During vsync lines, sync is low for 1536−113 = 1423 clocks per line (broad pulse).
  - Sync is high for 113 clocks at the serration.
